// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one imem request at a time,
// buffers the returned instruction for decode and squashes wrong-path responses.
module fetch_ctrl #(
    parameter int                     DATAWIDTH    = 32,
    parameter logic [DATAWIDTH-1:0]   RESET_VECTOR = '0,
    parameter int                     INST_BYTES   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 redirect_valid,
    input  logic [DATAWIDTH-1:0] redirect_pc,
    output logic                 imem_req,
    output logic [DATAWIDTH-1:0] imem_addr,
    input  logic                 imem_gnt,
    input  logic                 imem_rvalid,
    input  logic [DATAWIDTH-1:0] imem_rdata,
    output logic                 if_valid,
    output logic [DATAWIDTH-1:0] if_pc,
    output logic [DATAWIDTH-1:0] if_inst,
    input  logic                 if_ready,
    output logic                 misalign_o,
    output logic [DATAWIDTH-1:0] pc_o
);

    localparam int ALIGN_BITS = $clog2(INST_BYTES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [DATAWIDTH-1:0] r_pc;
    logic [DATAWIDTH-1:0] w_pc_next;
    logic [DATAWIDTH-1:0] r_if_pc;
    logic [DATAWIDTH-1:0] w_if_pc_next;
    logic [DATAWIDTH-1:0] r_if_inst;
    logic [DATAWIDTH-1:0] w_if_inst_next;
    logic                 r_discard;
    logic                 w_discard_next;
    logic                 r_req;
    logic                 r_if_valid;
    logic                 r_misalign;
    logic [DATAWIDTH-1:0] w_redirect_aligned;
    logic [DATAWIDTH-1:0] w_redirect_low;

    // Split the redirect target into its aligned part and the offending low bits.
    genvar gi;
    generate
        for (gi = 0; gi < DATAWIDTH; gi++) begin : g_align
            if (gi < ALIGN_BITS) begin : g_lo
                assign w_redirect_aligned[gi] = 1'b0;
                assign w_redirect_low[gi]     = redirect_pc[gi];
            end else begin : g_hi
                assign w_redirect_aligned[gi] = redirect_pc[gi];
                assign w_redirect_low[gi]     = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_discard_next = r_discard;
        w_if_pc_next   = r_if_pc;
        w_if_inst_next = r_if_inst;

        if (redirect_valid) begin
            w_pc_next = w_redirect_aligned;
        end

        case (r_state)
            S_IDLE: begin
                w_state_next = S_REQ;
            end
            S_REQ: begin
                if (imem_gnt) begin
                    w_state_next   = S_WAIT;
                    w_discard_next = redirect_valid;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    w_discard_next = 1'b0;
                    if (redirect_valid || r_discard) begin
                        w_state_next = S_REQ;
                    end else begin
                        w_state_next   = S_HOLD;
                        w_if_pc_next   = r_pc;
                        w_if_inst_next = imem_rdata;
                    end
                end else if (redirect_valid) begin
                    // The in-flight response now belongs to the wrong path.
                    w_discard_next = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    w_state_next = S_REQ;
                end else if (if_ready) begin
                    w_state_next = S_REQ;
                    w_pc_next    = r_pc + DATAWIDTH'(INST_BYTES);
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_VECTOR;
            r_discard  <= 1'b0;
            r_req      <= 1'b0;
            r_if_valid <= 1'b0;
            r_if_pc    <= '0;
            r_if_inst  <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_discard  <= w_discard_next;
            r_req      <= (w_state_next == S_REQ);
            r_if_valid <= (w_state_next == S_HOLD);
            r_if_pc    <= w_if_pc_next;
            r_if_inst  <= w_if_inst_next;
            r_misalign <= redirect_valid && (|w_redirect_low);
        end
    end

    assign imem_req   = r_req;
    assign imem_addr  = r_pc;
    assign pc_o       = r_pc;
    assign if_valid   = r_if_valid;
    assign if_pc      = r_if_pc;
    assign if_inst    = r_if_inst;
    assign misalign_o = r_misalign;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios followed by a randomized run, all
// checked against a transaction-level PC/memory model.
`timescale 1ns/1ps
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_ready;
    logic        misalign_o;
    logic [31:0] pc_o;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .DATAWIDTH   (32),
        .RESET_VECTOR(32'h0),
        .INST_BYTES  (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .if_ready      (if_ready),
        .misalign_o    (misalign_o),
        .pc_o          (pc_o)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int idle_run = 0;

    // memory behaviour knobs and in-flight request tracking
    int          gnt_pct  = 100;
    int          rv_min   = 0;
    int          rv_max   = 0;
    bit          junk_en  = 1'b0;
    bit          pending  = 1'b0;
    logic [31:0] p_addr   = '0;
    int          mem_wait = 0;

    // architectural expectations
    logic [31:0] exp_pc  = 32'h0;
    bit          exp_mis = 1'b0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h8) return 32'h00500093;
        if (a == 32'hC) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        logic        p_req;
        logic        p_valid;
        logic [31:0] p_a;
        imem_gnt = ($urandom_range(0, 99) < gnt_pct);
        if (pending && mem_wait == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memf(p_addr);
        end else if (!pending && junk_en) begin
            imem_rvalid = 1'($urandom_range(0, 1));
            imem_rdata  = $urandom;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        p_req   = imem_req;
        p_a     = imem_addr;
        p_valid = if_valid;
        if (pending && !rst) chk("one_outstanding", 32'(p_req), 32'd0);
        if (!rst && p_valid && if_ready && !redirect_valid)
            $display("fetch pc=%h inst=%h cycle=%0d", if_pc, if_inst, cyc);
        @(posedge clk);
        cyc++;
        if (rst) begin
            pending = 1'b0;
            exp_pc  = 32'h0;
            exp_mis = 1'b0;
        end else begin
            if (pending) begin
                if (mem_wait == 0) pending = 1'b0;
                else mem_wait--;
            end else if (p_req && imem_gnt) begin
                pending  = 1'b1;
                p_addr   = p_a;
                mem_wait = $urandom_range(rv_min, rv_max);
            end
            exp_mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
            else if (p_valid && if_ready) exp_pc = exp_pc + 32'd4;
        end
        #1;
        chk("pc_o", pc_o, exp_pc);
        chk("imem_addr", imem_addr, exp_pc);
        chk("misalign", 32'(misalign_o), 32'(exp_mis));
        if (rst) begin
            chk("rst_req", 32'(imem_req), 32'd0);
            chk("rst_valid", 32'(if_valid), 32'd0);
            chk("rst_if_pc", if_pc, 32'd0);
            chk("rst_if_inst", if_inst, 32'd0);
        end else begin
            if (if_valid) begin
                chk("if_pc", if_pc, exp_pc);
                chk("if_inst", if_inst, memf(exp_pc));
                chk("req_in_hold", 32'(imem_req), 32'd0);
            end
            if (p_valid && (if_ready || redirect_valid)) chk("valid_drop", 32'(if_valid), 32'd0);
            else if (p_valid) chk("valid_hold", 32'(if_valid), 32'd1);
        end
        idle_run = if_valid ? 0 : idle_run + 1;
    endtask

    task automatic wait_valid(input string tag);
        for (int k = 0; k < 20 && !if_valid; k++) step();
        chk(tag, 32'(if_valid), 32'd1);
    endtask

    int          n_ev;
    int          ev_k [4];
    logic [31:0] ev_pc[4];

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        if_ready       = 1'b1;
        n_ev           = 0;
        for (int i = 0; i < 4; i++) begin
            ev_k[i]  = 0;
            ev_pc[i] = '0;
        end

        // reset, then free fetch with immediate grant/response and ready held high
        step();
        step();
        rst = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k == 1) chk("first_req", 32'(imem_req), 32'd1);
            if (if_valid && n_ev < 4) begin
                ev_k[n_ev]  = k;
                ev_pc[n_ev] = if_pc;
                n_ev++;
            end
        end
        chk("n_fetch", 32'(n_ev), 32'd3);
        chk("first_valid_cyc", 32'(ev_k[0]), 32'd3);
        chk("spacing_1", 32'(ev_k[1] - ev_k[0]), 32'd3);
        chk("spacing_2", 32'(ev_k[2] - ev_k[1]), 32'd3);
        chk("seq_pc_0", ev_pc[0], 32'h0);
        chk("seq_pc_1", ev_pc[1], 32'h4);
        chk("seq_pc_2", ev_pc[2], 32'h8);

        // backpressure while holding the instruction at 0x8
        if_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_valid", 32'(if_valid), 32'd1);
            chk("bp_inst", if_inst, 32'h00500093);
            chk("bp_pc", if_pc, 32'h8);
            chk("bp_noreq", 32'(imem_req), 32'd0);
        end
        if_ready = 1'b1;
        rv_min   = 1;
        rv_max   = 1;
        step();
        chk("bp_release_req", 32'(imem_req), 32'd1);
        chk("bp_release_addr", imem_addr, 32'hC);

        // redirect while waiting; the stale 0xDEADBEEF response must be dropped
        step();
        chk("wait_noreq", 32'(imem_req), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        redirect_valid = 1'b0;
        step();
        chk("stale_drop_valid", 32'(if_valid), 32'd0);
        chk("redir_req", 32'(imem_req), 32'd1);
        chk("redir_addr", imem_addr, 32'h100);
        rv_min   = 0;
        rv_max   = 0;
        if_ready = 1'b0;
        wait_valid("redir_fetch_valid");
        chk("redir_if_pc", if_pc, 32'h100);
        chk("no_stale_inst", 32'(if_inst == 32'hDEADBEEF), 32'd0);

        // misaligned redirect in HOLD with ready high
        redirect_valid = 1'b1;
        redirect_pc    = 32'h202;
        if_ready       = 1'b1;
        step();
        redirect_valid = 1'b0;
        if_ready       = 1'b0;
        chk("mis_pulse", 32'(misalign_o), 32'd1);
        chk("mis_valid_drop", 32'(if_valid), 32'd0);
        chk("mis_addr", imem_addr, 32'h200);
        chk("mis_req", 32'(imem_req), 32'd1);
        step();
        chk("mis_once", 32'(misalign_o), 32'd0);
        chk("mis_pc_hold", pc_o, 32'h200);

        // PC wrap at the top of the address space
        wait_valid("pre_wrap_valid");
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFFFFFC;
        step();
        redirect_valid = 1'b0;
        wait_valid("wrap_fetch_valid");
        chk("wrap_if_pc", if_pc, 32'hFFFFFFFC);
        if_ready = 1'b1;
        step();
        if_ready = 1'b0;
        chk("wrap_pc", pc_o, 32'h0);
        chk("wrap_req", 32'(imem_req), 32'd1);

        // reset during WAIT, then grant withheld for 3 cycles
        gnt_pct        = 0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        redirect_valid = 1'b0;
        chk("retarget_addr", imem_addr, 32'h40);
        gnt_pct = 100;
        rv_min  = 3;
        rv_max  = 3;
        step();
        step();
        rst     = 1'b1;
        gnt_pct = 0;
        step();
        rst = 1'b0;
        chk("rst_wait_pc", pc_o, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("post_rst_req", 32'(imem_req), 32'd1);
            chk("post_rst_addr", imem_addr, 32'h0);
        end
        gnt_pct = 100;
        step();
        chk("post_rst_granted", 32'(imem_req), 32'd0);

        // randomized traffic: grants, latencies, backpressure, redirects, resets
        gnt_pct = 60;
        rv_min  = 0;
        rv_max  = 3;
        junk_en = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if_ready       = ($urandom_range(0, 99) < 70);
            redirect_valid = ($urandom_range(0, 99) < 8);
            case ($urandom_range(0, 3))
                0:       redirect_pc = $urandom;
                1:       redirect_pc = $urandom & 32'hFFC;
                2:       redirect_pc = 32'hFFFFFFF0 | ($urandom & 32'hF);
                default: redirect_pc = $urandom & 32'hFF;
            endcase
            rst = ($urandom_range(0, 999) < 2);
            step();
            if (idle_run > 400) begin
                chk("liveness", 32'(idle_run), 32'd0);
                break;
            end
        end
        rst            = 1'b0;
        redirect_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
